// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared types and saturating arithmetic for the histogram engine
package hist_pkg;

  // Engine sequencing: zeroing sweep, accumulate, wait for pipeline, stream out
  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_READOUT = 2'd3
  } hist_state_e;

  // Widest counter the saturating helpers handle
  localparam int unsigned SAT_MAX_W = 32;

  // Add two values and clamp the result to the largest w-bit value
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          w
  );
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
    if (sum > lim) begin
      return lim[SAT_MAX_W-1:0];
    end
    return sum[SAT_MAX_W-1:0];
  endfunction

  // True when a + b does not fit in w bits
  function automatic logic add_overflows(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          w
  );
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
    return sum > lim;
  endfunction

endpackage

// File: rtl/hist_bin_mem.sv
// rtl/hist_bin_mem.sv - behavioural 1R1W bin memory, synchronous read-first read port
module hist_bin_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write and registered read; a same-address read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/hist_accumulator.sv
// rtl/hist_accumulator.sv - histogram RMW engine with forwarding, clear sweep and readout
module hist_accumulator
  import hist_pkg::*;
#(
  parameter int unsigned BIN_ADDR_W    = 8,
  parameter int unsigned COUNT_W       = 17,
  parameter int unsigned WEIGHT_W      = 4,
  parameter int unsigned CLEAR_ON_READ = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BIN_ADDR_W-1:0] in_bin_i,
  input  logic [WEIGHT_W-1:0]   in_weight_i,
  input  logic                  clear_start_i,
  input  logic                  rd_start_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [BIN_ADDR_W-1:0] out_bin_o,
  output logic [COUNT_W-1:0]    out_count_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  sat_o
);

  localparam logic [BIN_ADDR_W-1:0] LAST_BIN = {BIN_ADDR_W{1'b1}};
  localparam logic [BIN_ADDR_W-1:0] ONE_BIN  = BIN_ADDR_W'(1);

  hist_state_e           state;
  logic [BIN_ADDR_W-1:0] clr_ptr;
  logic [BIN_ADDR_W-1:0] rd_ptr;
  logic                  rd_done;
  logic                  drain_to_clear;
  logic                  ready_q;

  logic                  accept;
  logic                  rd_issue;
  logic                  pop;
  logic                  push;
  logic [2:0]            occ_after;

  logic                  s1_valid;
  logic [BIN_ADDR_W-1:0] s1_bin;
  logic [WEIGHT_W-1:0]   s1_weight;
  logic [COUNT_W-1:0]    s1_old;
  logic [COUNT_W-1:0]    s1_sum;
  logic                  s1_ovf;

  logic                  fwd_valid;
  logic [BIN_ADDR_W-1:0] fwd_bin;
  logic [COUNT_W-1:0]    fwd_data;

  logic                  mem_we;
  logic [BIN_ADDR_W-1:0] mem_waddr;
  logic [COUNT_W-1:0]    mem_wdata;
  logic                  mem_re;
  logic [BIN_ADDR_W-1:0] mem_raddr;
  logic [COUNT_W-1:0]    mem_rdata;

  logic                  rd_inflight;
  logic [BIN_ADDR_W-1:0] rd_inflight_bin;

  logic [1:0]            occ;
  logic [BIN_ADDR_W-1:0] slot0_bin;
  logic [COUNT_W-1:0]    slot0_cnt;
  logic [BIN_ADDR_W-1:0] slot1_bin;
  logic [COUNT_W-1:0]    slot1_cnt;

  logic                  sat_q;

  assign accept = in_valid_i && ready_q;
  assign pop    = (occ != 2'd0) && out_ready_i;
  assign push   = rd_inflight;

  // Buffer slots still spoken for once this cycle's pop and the returning read settle
  assign occ_after = 3'(occ) - 3'(pop) + 3'(rd_inflight);
  assign rd_issue  = (state == ST_READOUT) && !rd_done && (occ_after < 3'd2);

  assign mem_re    = accept || rd_issue;
  assign mem_raddr = rd_issue ? rd_ptr : in_bin_i;

  hist_bin_mem #(
    .ADDR_W (BIN_ADDR_W),
    .DATA_W (COUNT_W)
  ) u_mem (
    .clk   (clk_i),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // S1 takes the last cycle's write when the read-first memory returned stale data
  assign s1_old = (fwd_valid && (fwd_bin == s1_bin)) ? fwd_data : mem_rdata;
  assign s1_sum = COUNT_W'(sat_add(SAT_MAX_W'(s1_old), SAT_MAX_W'(s1_weight), COUNT_W));
  assign s1_ovf = add_overflows(SAT_MAX_W'(s1_old), SAT_MAX_W'(s1_weight), COUNT_W);

  // Single write port shared by the clear sweep, accumulate writeback and clear-on-read
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr;
    mem_wdata = '0;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr;
    end else if (s1_valid) begin
      mem_we    = 1'b1;
      mem_waddr = s1_bin;
      mem_wdata = s1_sum;
    end else if (rd_issue && (CLEAR_ON_READ != 0)) begin
      mem_we    = 1'b1;
      mem_waddr = rd_ptr;
    end
  end

  // Accumulate pipeline stage S1: bin and weight of the sample whose read is returning
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_bin    <= '0;
      s1_weight <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_bin    <= in_bin_i;
        s1_weight <= in_weight_i;
      end
    end
  end

  // One-entry record of the previous cycle's memory write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fwd_valid <= 1'b0;
      fwd_bin   <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= mem_we;
      fwd_bin   <= mem_waddr;
      fwd_data  <= mem_wdata;
    end
  end

  // Sticky saturation flag, dropped by the clear sweep
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_q <= 1'b0;
    end else if (state == ST_CLEAR) begin
      sat_q <= 1'b0;
    end else if (s1_valid && s1_ovf) begin
      sat_q <= 1'b1;
    end
  end

  // Control FSM with sweep pointers and the registered sample-ready output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_CLEAR;
      clr_ptr        <= '0;
      rd_ptr         <= '0;
      rd_done        <= 1'b0;
      drain_to_clear <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + ONE_BIN;
          if (clr_ptr == LAST_BIN) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear_start_i) begin
            state          <= ST_DRAIN;
            drain_to_clear <= 1'b1;
            ready_q        <= 1'b0;
          end else if (rd_start_i) begin
            state          <= ST_DRAIN;
            drain_to_clear <= 1'b0;
            ready_q        <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!s1_valid) begin
            if (drain_to_clear) begin
              state   <= ST_CLEAR;
              clr_ptr <= '0;
            end else begin
              state   <= ST_READOUT;
              rd_ptr  <= '0;
              rd_done <= 1'b0;
            end
          end
        end
        ST_READOUT: begin
          if (rd_issue) begin
            rd_ptr <= rd_ptr + ONE_BIN;
            if (rd_ptr == LAST_BIN) begin
              rd_done <= 1'b1;
            end
          end
          if (pop && out_last_o) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_ptr <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag of the readout read whose data arrives next cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_inflight     <= 1'b0;
      rd_inflight_bin <= '0;
    end else begin
      rd_inflight     <= rd_issue;
      rd_inflight_bin <= rd_ptr;
    end
  end

  // Two-entry output buffer, slot0 is the head presented to the consumer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ       <= 2'd0;
      slot0_bin <= '0;
      slot0_cnt <= '0;
      slot1_bin <= '0;
      slot1_cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            slot0_bin <= rd_inflight_bin;
            slot0_cnt <= mem_rdata;
          end else begin
            slot1_bin <= rd_inflight_bin;
            slot1_cnt <= mem_rdata;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0_bin <= slot1_bin;
          slot0_cnt <= slot1_cnt;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0_bin <= rd_inflight_bin;
            slot0_cnt <= mem_rdata;
          end else begin
            slot0_bin <= slot1_bin;
            slot0_cnt <= slot1_cnt;
            slot1_bin <= rd_inflight_bin;
            slot1_cnt <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (occ != 2'd0);
  assign out_bin_o   = slot0_bin;
  assign out_count_o = slot0_cnt;
  assign out_last_o  = (occ != 2'd0) && (slot0_bin == LAST_BIN);
  assign busy_o      = (state != ST_IDLE) || s1_valid;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_hist_accumulator.sv
// tb/tb_hist_accumulator.sv - directed bench for hist_accumulator, plain and clear-on-read instances
module tb_hist_accumulator;

  localparam int BINS  = 256;
  localparam int CMAX  = 131071;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_bin;
  logic [3:0]  in_weight;
  logic        clear_start;
  logic        rd_start;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_last0, busy0, sat0;
  logic [7:0]  out_bin0;
  logic [16:0] out_count0;
  logic        in_ready1, out_valid1, out_last1, busy1, sat1;
  logic [7:0]  out_bin1;
  logic [16:0] out_count1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp0 [BINS];
  int exp1 [BINS];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  hist_accumulator #(.CLEAR_ON_READ(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_bin_i(in_bin), .in_weight_i(in_weight), .clear_start_i(clear_start),
    .rd_start_i(rd_start), .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .out_bin_o(out_bin0), .out_count_o(out_count0), .out_last_o(out_last0),
    .busy_o(busy0), .sat_o(sat0)
  );

  hist_accumulator #(.CLEAR_ON_READ(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_bin_i(in_bin), .in_weight_i(in_weight), .clear_start_i(clear_start),
    .rd_start_i(rd_start), .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .out_bin_o(out_bin1), .out_count_o(out_count1), .out_last_o(out_last1),
    .busy_o(busy1), .sat_o(sat1)
  );

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  task automatic model_add(input int b, input int w);
    exp0[b] = (exp0[b] + w > CMAX) ? CMAX : exp0[b] + w;
    exp1[b] = (exp1[b] + w > CMAX) ? CMAX : exp1[b] + w;
  endtask

  task automatic model_zero();
    for (int i = 0; i < BINS; i++) begin
      exp0[i] = 0;
      exp1[i] = 0;
    end
  endtask

  task automatic send(input int b, input int w);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_bin    = 8'(b);
    in_weight = 4'(w);
    while (!in_ready0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) check("send_timeout", t, 0);
    model_add(b, w);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic readout(input bit rnd, input int sbin, input int sw);
    int idx, t, gaps;
    bit started;
    idx = 0; t = 0; gaps = 0; started = 0;
    rd_start = 1'b1;
    if (sbin >= 0) begin
      in_valid  = 1'b1;
      in_bin    = 8'(sbin);
      in_weight = 4'(sw);
      model_add(sbin, sw);
    end
    @(negedge clk);
    rd_start = 1'b0;
    in_valid = 1'b0;
    while (idx < BINS && t < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid0) begin
        started = 1;
        check("rd_bin", out_bin0, idx);
        check("rd_cnt0", out_count0, exp0[idx]);
        check("rd_last", out_last0, idx == BINS - 1);
        check("rd_v1", out_valid1, 1);
        check("rd_bin1", out_bin1, idx);
        check("rd_cnt1", out_count1, exp1[idx]);
        if (out_ready) idx++;
      end else if (started) begin
        gaps++;
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b1;
    check("rd_beats", idx, BINS);
    if (!rnd) check("rd_gaps", gaps, 0);
    check("rd_idle", busy0, 0);
    check("rd_last1", out_last1, 0);
    for (int i = 0; i < BINS; i++) exp1[i] = 0;
  endtask

  task automatic clear_sweep(input bit with_rd);
    int t;
    t = 0;
    clear_start = 1'b1;
    rd_start    = with_rd;
    @(negedge clk);
    clear_start = 1'b0;
    rd_start    = 1'b0;
    while (busy0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("clr_busy", busy0, 0);
    check("clr_len", t, 257);
    check("clr_sat0", sat0, 0);
    check("clr_sat1", sat1, 0);
    model_zero();
  endtask

  initial begin
    int t, c0;
    rst = 1'b1;
    in_valid = 1'b0; in_bin = '0; in_weight = '0;
    clear_start = 1'b0; rd_start = 1'b0; out_ready = 1'b1;
    model_zero();
    repeat (3) @(negedge clk);

    check("rst_ready", in_ready0, 0);
    check("rst_valid", out_valid0, 0);
    check("rst_bin", out_bin0, 0);
    check("rst_count", out_count0, 0);
    check("rst_last", out_last0, 0);
    check("rst_busy", busy0, 1);
    check("rst_sat", sat0, 0);
    check("rst_busy1", busy1, 1);

    rst = 1'b0;
    t = 0;
    while (busy0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("init_clr_len", t, 256);
    check("init_ready0", in_ready0, 1);
    check("init_ready1", in_ready1, 1);

    readout(0, -1, 0);

    c0 = cyc;
    for (int i = 0; i < 10; i++) send(5, 1);
    check("tput", cyc - c0, 10);
    readout(0, -1, 0);

    for (int i = 0; i < 8; i++) send((i % 2) ? 4 : 3, 15);
    readout(1, 11, 2);

    for (int i = 0; i < 8738; i++) send(7, 15);
    @(negedge clk);
    check("pre_sat0", sat0, 0);
    send(7, 15);
    @(negedge clk);
    check("sat0", sat0, 1);
    check("sat1", sat1, 1);
    readout(0, -1, 0);
    readout(0, -1, 0);
    clear_sweep(0);

    send(9, 3);
    clear_sweep(1);
    readout(0, -1, 0);

    send(20, 6);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_valid", out_valid0, 1);
    rst = 1'b1;
    #1;
    check("mrst_valid0", out_valid0, 0);
    check("mrst_valid1", out_valid1, 0);
    check("mrst_ready", in_ready0, 0);
    check("mrst_busy", busy0, 1);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (busy0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("mrst_clr_len", t, 256);
    model_zero();
    readout(0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
